mips_alu_regfile: RTL and testbench

- Execution-datapath core of the 5-stage MIPS pipeline: a 32x32-bit register file (two read ports, one write port) and a 32-bit integer ALU.
- Decode reads operands from the register file. Write-back writes results into it. Execute drives the ALU.
- The two halves share only clock and reset. All operand multiplexing (ALUSrc, MemToReg, RegDst) is outside this block.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_alu.sv | 37 +++
 rtl/mips_alu_regfile.sv | 69 ++++++
 tb/tb_mips_alu_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and ALU operation codes for the MIPS execution datapath.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit MIPS integer ALU; shifts take their distance from shamt
// and operate on operand B only.
module mips_alu
  import mips_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  input  logic [4:0]   i_shamt,
  output logic [W-1:0] o_y,
  output logic         o_zero
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLL: o_y = i_b << i_shamt;
      ALU_SRL: o_y = i_b >> i_shamt;
      ALU_NOR: o_y = ~(i_a | i_b);
      ALU_SLT: o_y = {{(W-1){1'b0}}, w_lt};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/mips_alu_regfile.sv
// Execution-datapath core: 32x32 register file with write-first bypass on both
// read ports, alongside the standalone combinational ALU.
module mips_alu_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int NREGS  = mips_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [2:0]        alu_op,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_live;

  // Writes to r0 are dropped so the bypass never forwards into it either.
  assign w_wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = r_regs[rs_addr];
    if (rs_addr == '0)
      rd_data1 = '0;
    else if (w_wr_live && (wr_addr == rs_addr))
      rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = r_regs[rt_addr];
    if (rt_addr == '0)
      rd_data2 = '0;
    else if (w_wr_live && (wr_addr == rt_addr))
      rd_data2 = wr_data;
  end

  mips_alu #(
    .W (DATA_W)
  ) u_alu (
    .i_a     (alu_a),
    .i_b     (alu_b),
    .i_op    (alu_op),
    .i_shamt (shamt),
    .o_y     (alu_out),
    .o_zero  (zero)
  );

endmodule

// File: tb/tb_mips_alu_regfile.sv
// Directed-vector bench for the register file and ALU with hand-computed expectations.
module tb_mips_alu_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        zero;

  int n_chk = 0;
  int n_err = 0;

  mips_alu_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .shamt    (shamt),
    .alu_out  (alu_out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_y, input logic exp_z);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    shamt  = sh;
    #1;
    check({tag, ".out"}, alu_out, exp_y);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_z});
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("%s.rd1[%0d]", tag, i), rd_data1, 32'h0);
      check($sformatf("%s.rd2[%0d]", tag, 31 - i), rd_data2, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0;
    alu_a = '0; alu_b = '0; alu_op = 3'd0; shamt = '0;

    // Reset, then every register reads back 0.
    tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Plain write then read next cycle.
    reg_write(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5; rt_addr = 5'd5; #1;
    check("wr_r5.rd1", rd_data1, 32'hDEADBEEF);
    check("wr_r5.rd2", rd_data2, 32'hDEADBEEF);

    // r0 discards writes, including through the bypass path.
    wr_addr = 5'd0; wr_data = 32'h1234; wr_en = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    check("r0_bypass", rd_data1, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    check("r0_after.rd1", rd_data1, 32'h0);
    check("r0_after.rd2", rd_data2, 32'h0);

    // wr_en=0 leaves the target untouched.
    reg_write(5'd6, 32'h000000A5);
    wr_addr = 5'd6; wr_data = 32'd7; wr_en = 1'b0;
    rs_addr = 5'd6; #1;
    check("noen_before", rd_data1, 32'h000000A5);
    tick();
    check("noen_after", rd_data1, 32'h000000A5);

    // Bypass: same-cycle visibility on both ports, then persisted.
    wr_addr = 5'd9; wr_data = 32'h55; wr_en = 1'b1;
    rs_addr = 5'd9; rt_addr = 5'd9; #1;
    check("bypass_pre.rd1", rd_data1, 32'h55);
    check("bypass_pre.rd2", rd_data2, 32'h55);
    tick();
    wr_en = 1'b0; #1;
    check("bypass_post.rd1", rd_data1, 32'h55);
    check("bypass_post.rd2", rd_data2, 32'h55);
    rs_addr = 5'd5; rt_addr = 5'd9; #1;
    check("dual.rd1", rd_data1, 32'hDEADBEEF);
    check("dual.rd2", rd_data2, 32'h55);

    // ALU vectors.
    alu_vec("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h00000000, 1'b1);
    alu_vec("add",      3'd0, 32'h00000010, 32'h22,       5'd0, 32'h00000032, 1'b0);
    alu_vec("sub_neg",  3'd1, 32'd5,        32'd7,        5'd0, 32'hFFFFFFFE, 1'b0);
    alu_vec("and",      3'd2, 32'hF0F0,     32'h0FF0,     5'd0, 32'h000000F0, 1'b0);
    alu_vec("or",       3'd3, 32'hF000,     32'h000F,     5'd0, 32'h0000F00F, 1'b0);
    alu_vec("nor",      3'd6, 32'h0,        32'h0,        5'd0, 32'hFFFFFFFF, 1'b0);
    alu_vec("sll1",     3'd4, 32'hFFFFFFFF, 32'h80000001, 5'd1, 32'h00000002, 1'b0);
    alu_vec("srl1",     3'd5, 32'hFFFFFFFF, 32'h80000001, 5'd1, 32'h40000000, 1'b0);
    alu_vec("sll0",     3'd4, 32'h12345678, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
    alu_vec("srl0",     3'd5, 32'h12345678, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
    alu_vec("srl31",    3'd5, 32'h0,        32'h80000000, 5'd31, 32'h00000001, 1'b0);
    alu_vec("srl_zero", 3'd5, 32'hFFFFFFFF, 32'h00000001, 5'd1, 32'h00000000, 1'b1);
    alu_vec("slt_neg",  3'd7, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h00000001, 1'b0);
    alu_vec("slt_pos",  3'd7, 32'h1,        32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1);
    alu_vec("slt_eq",   3'd7, 32'd3,        32'd3,        5'd0, 32'h00000000, 1'b1);

    // Reset with a pending write: write dropped, ALU unaffected.
    alu_op = 3'd0; alu_a = 32'd2; alu_b = 32'd3; shamt = 5'd0;
    wr_addr = 5'd5; wr_data = 32'hFF; wr_en = 1'b1; rst_n = 1'b0; #1;
    check("rst_alu_during", alu_out, 32'd5);
    tick();
    rst_n = 1'b1; wr_en = 1'b0; #1;
    check("rst_alu_after", alu_out, 32'd5);
    check_all_zero("midreset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
